// File: rtl/grid_ram.sv
// Dual-read-port cell memory for the snake playfield, addressed as {y, x}.
// A built-in sweep fills every cell with CLEAR_VAL after reset or on a clear request.
//
//   state | meaning
//   IDLE  | normal operation, game-port writes accepted
//   CLEAR | sweep writes CLEAR_VAL to clr_addr each cycle, game writes dropped
module grid_ram #(
    parameter int                 X_BITS    = 4,
    parameter int                 Y_BITS    = 4,
    parameter int                 DATA_W    = 4,
    parameter logic [DATA_W-1:0]  CLEAR_VAL = '0
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              clear_i,
    output logic              busy_o,
    input  logic              write_en_i,
    input  logic [X_BITS-1:0] wr_x_i,
    input  logic [Y_BITS-1:0] wr_y_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [X_BITS-1:0] rd_x_i,
    input  logic [Y_BITS-1:0] rd_y_i,
    output logic [DATA_W-1:0] rd_data_o,
    input  logic [X_BITS-1:0] vga_x_i,
    input  logic [Y_BITS-1:0] vga_y_i,
    output logic [DATA_W-1:0] vga_data_o
);
    localparam int A_W = X_BITS + Y_BITS;
    localparam int N   = 1 << A_W;
    localparam logic [A_W-1:0] LAST_ADDR = '1;

    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_e;

    state_e            state_q, state_d;
    logic [A_W-1:0]    clr_addr_q, clr_addr_d;
    logic [DATA_W-1:0] mem_q [N];
    logic [DATA_W-1:0] rd_data_q, vga_data_q;

    logic              sweep;
    logic              mem_we;
    logic [A_W-1:0]    mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= CLEAR;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            IDLE: begin
                if (clear_i) begin
                    state_d    = CLEAR;
                    clr_addr_d = '0;
                end
            end
            CLEAR: begin
                if (clear_i) begin
                    clr_addr_d = '0;
                end else if (clr_addr_q == LAST_ADDR) begin
                    state_d    = IDLE;
                    clr_addr_d = '0;
                end else begin
                    clr_addr_d = clr_addr_q + 1'b1;
                end
            end
            default: begin
                state_d    = CLEAR;
                clr_addr_d = '0;
            end
        endcase
    end

    // A request cycle already counts as busy, so reads issued in it return CLEAR_VAL too.
    always_comb begin
        sweep     = (state_q == CLEAR) || clear_i;
        mem_we    = 1'b0;
        mem_waddr = {wr_y_i, wr_x_i};
        mem_wdata = wr_data_i;
        case (state_q)
            IDLE: begin
                mem_we = write_en_i && !clear_i;
            end
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_addr_q;
                mem_wdata = CLEAR_VAL;
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_data_q  <= '0;
            vga_data_q <= '0;
        end else begin
            rd_data_q  <= sweep ? CLEAR_VAL : mem_q[{rd_y_i, rd_x_i}];
            vga_data_q <= sweep ? CLEAR_VAL : mem_q[{vga_y_i, vga_x_i}];
        end
    end

    assign busy_o     = sweep;
    assign rd_data_o  = rd_data_q;
    assign vga_data_o = vga_data_q;
endmodule

// File: tb/tb_grid_ram.sv
// Scoreboard bench for grid_ram: a default instance and a 5x3x2 / CLEAR_VAL=1 instance
// share one randomized stimulus stream, checked against a cell-array reference model.
module tb_grid_ram;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic       we = 1'b0;
    logic [7:0] wa = '0, ra = '0, va = '0;
    logic [3:0] wd = '0;

    logic       busy0, busy1;
    logic [3:0] rd0, vga0;
    logic [1:0] rd1, vga1;

    always #5 clk = ~clk;

    grid_ram u_dut0 (
        .clk_i(clk), .rst_n_i(rst_n), .clear_i(clear), .busy_o(busy0),
        .write_en_i(we), .wr_x_i(wa[3:0]), .wr_y_i(wa[7:4]), .wr_data_i(wd),
        .rd_x_i(ra[3:0]), .rd_y_i(ra[7:4]), .rd_data_o(rd0),
        .vga_x_i(va[3:0]), .vga_y_i(va[7:4]), .vga_data_o(vga0)
    );

    grid_ram #(.X_BITS(5), .Y_BITS(3), .DATA_W(2), .CLEAR_VAL(2'd1)) u_dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .clear_i(clear), .busy_o(busy1),
        .write_en_i(we), .wr_x_i(wa[4:0]), .wr_y_i(wa[7:5]), .wr_data_i(wd[1:0]),
        .rd_x_i(ra[4:0]), .rd_y_i(ra[7:5]), .rd_data_o(rd1),
        .vga_x_i(va[4:0]), .vga_y_i(va[7:5]), .vga_data_o(vga1)
    );

    typedef struct {int rd; int vga;} exp_t;
    exp_t q0[$];
    exp_t q1[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: both instances are 256 cells deep; a sweep is a count of edges left.
    int mem_m [2][256];
    int cv   [2] = '{0, 1};
    int mask [2] = '{15, 3};
    int remaining;
    bit busy_s;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_fill();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 256; i++) mem_m[k][i] = cv[k];
        remaining = 256;
    endfunction

    // Called at a negedge: drive one cycle, predict, then advance to the next negedge.
    task automatic step(input bit c, input bit w, input int a, input int d, input int r, input int v);
        bit   bm;
        exp_t e;
        clear = c; we = w; wa = a[7:0]; wd = d[3:0]; ra = r[7:0]; va = v[7:0];
        #1;
        bm = (remaining > 0) || c;
        busy_s = busy0;
        chk("busy0", {31'd0, busy0}, {31'd0, bm});
        chk("busy1", {31'd0, busy1}, {31'd0, bm});
        e.rd  = bm ? cv[0] : mem_m[0][r & 255];
        e.vga = bm ? cv[0] : mem_m[0][v & 255];
        q0.push_back(e);
        e.rd  = bm ? cv[1] : mem_m[1][r & 255];
        e.vga = bm ? cv[1] : mem_m[1][v & 255];
        q1.push_back(e);
        if (c) model_fill();
        else if (remaining > 0) remaining--;
        else if (w) for (int k = 0; k < 2; k++) mem_m[k][a & 255] = d & mask[k];
        @(negedge clk);
    endtask

    task automatic rand_step(input bit allow_we);
        int a;
        a = $urandom_range(0, 255);
        step(1'b0, allow_we ? 1'($urandom_range(0, 1)) : 1'b0, a, $urandom_range(0, 15),
             ($urandom_range(0, 1) != 0) ? a : $urandom_range(0, 255),
             ($urandom_range(0, 2) == 0) ? a : $urandom_range(0, 255));
    endtask

    task automatic count_busy(input bit allow_we, output int cnt);
        cnt = 0;
        for (int i = 0; i < 400; i++) begin
            rand_step(allow_we);
            if (busy_s) cnt++;
            else break;
        end
    endtask

    initial begin
        forever begin
            exp_t e;
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                chk("rd0", {28'd0, rd0}, e.rd);
                chk("vga0", {28'd0, vga0}, e.vga);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chk("rd1", {30'd0, rd1}, e.rd);
                chk("vga1", {30'd0, vga1}, e.vga);
            end
        end
    end

    initial begin
        int cnt;
        bit first;
        repeat (3) @(negedge clk);
        chk("rst_busy0", {31'd0, busy0}, 1);
        chk("rst_busy1", {31'd0, busy1}, 1);
        chk("rst_rd0", {28'd0, rd0}, 0);
        chk("rst_vga0", {28'd0, vga0}, 0);
        chk("rst_rd1", {30'd0, rd1}, 0);
        chk("rst_vga1", {30'd0, vga1}, 0);
        rst_n = 1'b1;
        model_fill();
        count_busy(1'b0, cnt);
        chk("reset_sweep_len", cnt, 256);

        step(0, 0, 0, 0, 8'h00, 8'h00);
        step(0, 0, 0, 0, 8'hFF, 8'hFF);
        step(0, 0, 0, 0, 8'h97, 8'h97);

        step(0, 1, 8'h53, 4'hA, 0, 0);
        step(0, 1, 8'h0F, 4'h7, 8'h53, 8'h0F);
        step(0, 0, 0, 0, 8'h53, 8'h0F);

        step(0, 1, 8'h22, 4'h3, 0, 0);
        step(0, 1, 8'h22, 4'hC, 8'h22, 8'h22);
        step(0, 0, 0, 0, 8'h22, 8'h22);

        repeat (300) rand_step(1'b1);
        for (int i = 0; i < 16; i++) step(0, 1, i * 17, 15 - i, 0, 0);

        step(1, 1, 8'h11, 4'h9, 8'h11, 8'h22);
        first = busy_s;
        count_busy(1'b1, cnt);
        chk("clear_busy_len", first + cnt, 257);
        for (int i = 0; i < 256; i++) step(0, 0, 0, 0, i, 255 - i);

        repeat (40) rand_step(1'b1);
        step(1, 0, 0, 0, 0, 0);
        repeat (99) rand_step(1'b1);
        step(1, 0, 0, 0, 8'h53, 8'h22);
        count_busy(1'b1, cnt);
        chk("restart_busy_len", cnt, 256);

        step(0, 1, 8'hFF, 2, 0, 0);
        step(0, 0, 0, 0, 8'hFF, 8'hFF);
        step(0, 0, 0, 0, 8'hFE, 8'hFF);

        repeat (60) rand_step(1'b1);
        step(1, 0, 0, 0, 0, 0);
        repeat (50) rand_step(1'b1);
        #2;
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        #1;
        chk("midrst_busy0", {31'd0, busy0}, 1);
        chk("midrst_rd0", {28'd0, rd0}, 0);
        chk("midrst_vga1", {30'd0, vga1}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_fill();
        count_busy(1'b1, cnt);
        chk("midrst_sweep_len", cnt, 256);
        repeat (200) rand_step(1'b1);
        for (int i = 0; i < 64; i++) step(0, 0, 0, 0, i * 4, i * 4 + 1);
        step(0, 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
